alu_arbiter: RTL and testbench

Two-port arbiter that shares the single combinational ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/branch helper. It accepts operations over valid/ready handshakes and drives the shared ALU operand and control inputs. It captures the ALU result into a per-requester response register, presented one cycle after acceptance. Total throughput is one operation per cycle across both requesters.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters (0 = execute stage,
//   1 = address/branch helper). At most one operation is accepted per cycle.
//   The accepted operation's operands/control drive the ALU. Its result is
//   captured into that requester's response register, valid one cycle after
//   acceptance.
//
//   Build option: define ALU_ARB_RR_EN for round-robin contention using
//   last_grant. Without it, requester 0 always wins contention and requester 1
//   can starve.
//
// Ports (i = 0, 1):
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_i / req_ready_i request handshake (ready == grant)
//   req_a_i, req_b_i          32-bit operands
//   req_aluc_i                6-bit ALU control, forwarded unchanged
//   rsp_valid_i / rsp_ready_i response handshake
//   rsp_result_i              registered ALU result
//   alu_a, alu_b, alu_aluc    shared ALU inputs (0 when nothing is granted)
//   alu_result                shared ALU combinational result
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [5:0]  req_aluc_0,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic [31:0] rsp_result_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  input  logic [5:0]  req_aluc_1,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result_1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_aluc,
  input  logic [31:0] alu_result
);

  logic        rsp_valid_0_q, rsp_valid_0_d;
  logic        rsp_valid_1_q, rsp_valid_1_d;
  logic [31:0] rsp_result_0_q, rsp_result_0_d;
  logic [31:0] rsp_result_1_q, rsp_result_1_d;
  logic        elig_0, elig_1;
  logic        grant_0, grant_1;

`ifdef ALU_ARB_RR_EN
  logic        last_grant_q, last_grant_d;
`endif

  // Eligibility and grant. Reset masks both so nothing is accepted during rst.
  always_comb begin
    elig_0 = !rst && req_valid_0 && (!rsp_valid_0_q || rsp_ready_0);
    elig_1 = !rst && req_valid_1 && (!rsp_valid_1_q || rsp_ready_1);
`ifdef ALU_ARB_RR_EN
    // Under contention the requester that was not granted last wins.
    grant_0 = elig_0 && (!elig_1 || last_grant_q);
`else
    grant_0 = elig_0;
`endif
    grant_1 = elig_1 && !grant_0;
  end

  // Shared ALU input mux.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = '0;
    if (grant_0) begin
      alu_a    = req_a_0;
      alu_b    = req_b_0;
      alu_aluc = req_aluc_0;
    end else if (grant_1) begin
      alu_a    = req_a_1;
      alu_b    = req_b_1;
      alu_aluc = req_aluc_1;
    end
  end

  // Response registers. A grant takes priority over a drain, so a response
  // consumed in the same cycle as a new acceptance stays valid with the new
  // result.
  always_comb begin
    rsp_valid_0_d  = rsp_valid_0_q;
    rsp_valid_1_d  = rsp_valid_1_q;
    rsp_result_0_d = rsp_result_0_q;
    rsp_result_1_d = rsp_result_1_q;
    if (grant_0) begin
      rsp_valid_0_d  = 1'b1;
      rsp_result_0_d = alu_result;
    end else if (rsp_ready_0) begin
      rsp_valid_0_d  = 1'b0;
    end
    if (grant_1) begin
      rsp_valid_1_d  = 1'b1;
      rsp_result_1_d = alu_result;
    end else if (rsp_ready_1) begin
      rsp_valid_1_d  = 1'b0;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_0)      last_grant_d = 1'b0;
    else if (grant_1) last_grant_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_0_q  <= 1'b0;
      rsp_valid_1_q  <= 1'b0;
      rsp_result_0_q <= '0;
      rsp_result_1_q <= '0;
`ifdef ALU_ARB_RR_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      rsp_valid_0_q  <= rsp_valid_0_d;
      rsp_valid_1_q  <= rsp_valid_1_d;
      rsp_result_0_q <= rsp_result_0_d;
      rsp_result_1_q <= rsp_result_1_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign req_ready_0  = grant_0;
  assign req_ready_1  = grant_1;
  assign rsp_valid_0  = rsp_valid_0_q;
  assign rsp_valid_1  = rsp_valid_1_q;
  assign rsp_result_0 = rsp_result_0_q;
  assign rsp_result_1 = rsp_result_1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of per-cycle vectors plus a reset-mid-op
// sequence. Expected results are queued on expected acceptance and popped
// when the response register should show them.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b001000;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLL = 6'b000101;
  localparam logic [5:0] OP_AND = 6'b000010;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
  logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
  logic [31:0] req_a_0, req_b_0, rsp_result_0;
  logic [31:0] req_a_1, req_b_1, rsp_result_1;
  logic [5:0]  req_aluc_0, req_aluc_1;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_aluc;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_aluc_0(req_aluc_0),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_result_0(rsp_result_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_aluc_1(req_aluc_1),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_result_1(rsp_result_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_result(alu_result)
  );

  // Simple ALU standing in for the shared datapath.
  always_comb begin
    case (alu_aluc)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLL:  alu_result = alu_a << alu_b[4:0];
      OP_AND:  alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic [5:0]  c0;
    logic        rr0;
    logic        v1;
    logic [31:0] a1, b1;
    logic [5:0]  c1;
    logic        rr1;
    logic        rdy0, rdy1;
    logic [31:0] ea, eb;
    logic [5:0]  ec;
    logic [31:0] res0, res1;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        exp_vld0, exp_vld1;
  logic [31:0] exp_res0, exp_res1;

  function automatic vec_t mk(logic v0, logic [31:0] a0, logic [31:0] b0, logic [5:0] c0,
                              logic rr0, logic v1, logic [31:0] a1, logic [31:0] b1,
                              logic [5:0] c1, logic rr1, logic rdy0, logic rdy1,
                              logic [31:0] res0, logic [31:0] res1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0; v.rr0 = rr0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr1 = rr1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.res0 = res0; v.res1 = res1;
    v.ea = rdy0 ? a0 : (rdy1 ? a1 : 32'd0);
    v.eb = rdy0 ? b0 : (rdy1 ? b1 : 32'd0);
    v.ec = rdy0 ? c0 : (rdy1 ? c1 : 6'd0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid_0 = v.v0; req_a_0 = v.a0; req_b_0 = v.b0; req_aluc_0 = v.c0;
    rsp_ready_0 = v.rr0;
    req_valid_1 = v.v1; req_a_1 = v.a1; req_b_1 = v.b1; req_aluc_1 = v.c1;
    rsp_ready_1 = v.rr1;
  endtask

  task automatic run_vec(input vec_t v, input int unsigned k);
    drive(v);
    @(negedge clk);
    chk($sformatf("v%0d ready0", k), {31'd0, req_ready_0}, {31'd0, v.rdy0});
    chk($sformatf("v%0d ready1", k), {31'd0, req_ready_1}, {31'd0, v.rdy1});
    chk($sformatf("v%0d alu_a", k), alu_a, v.ea);
    chk($sformatf("v%0d alu_b", k), alu_b, v.eb);
    chk($sformatf("v%0d alu_aluc", k), {26'd0, alu_aluc}, {26'd0, v.ec});
    chk($sformatf("v%0d rsp_valid0", k), {31'd0, rsp_valid_0}, {31'd0, exp_vld0});
    chk($sformatf("v%0d rsp_result0", k), rsp_result_0, exp_res0);
    chk($sformatf("v%0d rsp_valid1", k), {31'd0, rsp_valid_1}, {31'd0, exp_vld1});
    chk($sformatf("v%0d rsp_result1", k), rsp_result_1, exp_res1);
    if (v.rdy0) q0.push_back(v.res0);
    if (v.rdy1) q1.push_back(v.res1);
    @(posedge clk);
    #1;
    if (v.rdy0) begin
      exp_vld0 = 1'b1;
      exp_res0 = q0.pop_front();
    end else if (v.rr0) begin
      exp_vld0 = 1'b0;
    end
    if (v.rdy1) begin
      exp_vld1 = 1'b1;
      exp_res1 = q1.pop_front();
    end else if (v.rr1) begin
      exp_vld1 = 1'b0;
    end
  endtask

  initial begin
    // 0: idle
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // 1-4: contention straight after reset
`ifdef ALU_ARB_RR_EN
    vecs.push_back(mk(1, 10, 3, OP_SUB, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 1, 0, 7, 0));
    vecs.push_back(mk(1, 10, 3, OP_SUB, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 0, 1, 0, 32'hFF));
    vecs.push_back(mk(1, 10, 3, OP_SUB, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 1, 0, 7, 0));
    vecs.push_back(mk(1, 10, 3, OP_SUB, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 0, 1, 0, 32'hFF));
`else
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 10, 3, OP_SUB, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 1, 0, 7, 0));
`endif
    // 5: idle, 6: single add, 7: idle (response shows, then drains)
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 3, OP_ADD, 1, 0, 0, 0, 0, 1, 1, 0, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // 8: req0 sub -> 7
    vecs.push_back(mk(1, 10, 3, OP_SUB, 1, 0, 0, 0, 0, 1, 1, 0, 7, 0));
    // 9-10: req0 backpressured; req1 shift-left granted, then held
    vecs.push_back(mk(1, 32'hC, 32'hA, OP_AND, 0, 1, 1, 4, OP_SLL, 1, 0, 1, 0, 16));
    vecs.push_back(mk(1, 32'hC, 32'hA, OP_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 11: req0 drains and accepts in the same cycle; req1 drains
    vecs.push_back(mk(1, 32'hC, 32'hA, OP_AND, 1, 0, 0, 0, 0, 1, 1, 0, 8, 0));
    // 12: idle, observe
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Reset with requester 0 presenting an op.
    rst = 1'b1;
    drive(mk(1, 5, 3, OP_ADD, 1, 1, 1, 4, OP_SLL, 1, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst ready0", {31'd0, req_ready_0}, 32'd0);
    chk("rst ready1", {31'd0, req_ready_1}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst rsp_valid0", {31'd0, rsp_valid_0}, 32'd0);
    chk("rst rsp_result1", rsp_result_1, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_vld0 = 1'b0; exp_vld1 = 1'b0; exp_res0 = '0; exp_res1 = '0;

    for (int unsigned k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

    // Reset mid-operation: req1 accepted in t, rst in t+1.
    drive(mk(0, 0, 0, 0, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("mid ready1", {31'd0, req_ready_1}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(mk(1, 5, 3, OP_ADD, 1, 1, 32'hF0, 32'h0F, OP_XOR, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("mid rst ready0", {31'd0, req_ready_0}, 32'd0);
    chk("mid rst ready1", {31'd0, req_ready_1}, 32'd0);
    chk("mid rst alu_aluc", {26'd0, alu_aluc}, 32'd0);
    chk("mid rsp_valid1 pre", {31'd0, rsp_valid_1}, 32'd1);
    chk("mid rsp_result1 pre", rsp_result_1, 32'hFF);
    @(posedge clk);
    #1;
    chk("mid rsp_valid1 post", {31'd0, rsp_valid_1}, 32'd0);
    chk("mid rsp_result1 post", rsp_result_1, 32'd0);
    chk("mid rsp_result0 post", rsp_result_0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst ready0", {31'd0, req_ready_0}, 32'd1);
    chk("post rst ready1", {31'd0, req_ready_1}, 32'd0);
    chk("post rst alu_a", alu_a, 32'd5);
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("post rst rsp_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("post rst rsp_result0", rsp_result_0, 32'd8);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
